// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
//   Shared constants for the bit-serial subtract path: FSM state encoding
//   and the default operand width. The divider controller reuses both.
package serial_subtractor_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Request/result bundle for the serial subtractor.
//   start, in1, in2, b_in : request side (driven by the controller)
//   diff, b_out, ovf      : registered results
//   busy, done            : status / completion pulse
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             b_in;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, in1, in2, b_in,
    input  diff, b_out, ovf, busy, done
  );

  modport slave (
    input  start, in1, in2, b_in,
    output diff, b_out, ovf, busy, done
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor
//   One-bit combinational full subtractor: a - b - bin.
//   a, b, bin : operand bits and borrow-in
//   d         : difference bit
//   bout      : borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = in1 - in2 - b_in, LSB first, one bit per
//   clock over WIDTH cycles, through a single full-subtractor cell.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of serial_subtractor_if (start/operands in,
//          diff/b_out/ovf/busy/done out)
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; results hold; start latches the operands
//   RUN   | one bit per edge; last edge updates results and pulses done
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bo)
  );

  assign bus.busy = (state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      r_sr      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      bus.diff  <= '0;
      bus.b_out <= 1'b0;
      bus.ovf   <= 1'b0;
      bus.done  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.in1;
            b_sr   <= bus.in2;
            borrow <= bus.b_in;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          r_sr   <= {cell_d, r_sr[WIDTH-1:1]};
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            bus.diff  <= {cell_d, r_sr[WIDTH-1:1]};
            bus.b_out <= cell_bo;
            // On the last bit the cell sees the original operand MSBs, so
            // no separate copies of them need to be kept.
            bus.ovf   <= (a_sr[0] ^ b_sr[0]) & (cell_d ^ a_sr[0]);
            bus.done  <= 1'b1;
            cnt       <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         b_in;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bi);
    int ua, ub, sa, sb, bb, ud, sd;
    logic [W-1:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    bb = bi ? 1 : 0;
    ud = ua - ub - bb;
    sd = sa - sb - bb;
    d  = ud[W-1:0];
    bo = (ud < 0);
    ov = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
    return {d, bo, ov};
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where done shows.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, output logic [W+1:0] res);
    int busy_cnt;
    int done_early;
    bus.in1   = a;
    bus.in2   = b;
    bus.b_in  = bi;
    bus.start = 1'b1;
    @(posedge clk);
    busy_cnt   = 0;
    done_early = 0;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.start = 1'b0;
        bus.in1   = ~a;
        bus.in2   = ~b;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) done_early++;
    end
    check_eq({tag, "_busy_cycles"}, busy_cnt, W);
    check_eq({tag, "_done_early"}, done_early, 0);
    @(negedge clk);
    check_eq({tag, "_done_busy"}, {30'd0, bus.done, bus.busy}, 32'b10);
    res = {bus.diff, bus.b_out, bus.ovf};
  endtask

  initial begin
    logic [W+1:0] res;
    logic [W+1:0] exp;
    logic [W+1:0] q[$];
    int done_cnt;
    int done_at;
    logic [W+1:0] got4;

    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

    bus.start = 1'b0;
    bus.in1   = '0;
    bus.in2   = '0;
    bus.b_in  = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {19'd0, bus.diff, bus.b_out, bus.ovf, bus.busy, bus.done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, including borrow and overflow corners.
    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].in1, vecs[i].in2, vecs[i].b_in, res);
      check_eq($sformatf("vec%0d_diff", i), res[W+1:2], vecs[i].exp_diff);
      check_eq($sformatf("vec%0d_bout", i), res[1], vecs[i].exp_bout);
      check_eq($sformatf("vec%0d_ovf", i), res[0], vecs[i].exp_ovf);
      @(negedge clk);
      check_eq($sformatf("vec%0d_done_pulse", i), bus.done, 1'b0);
    end

    // Start re-asserted with other operands during RUN must be ignored.
    bus.in1   = 8'h5A;
    bus.in2   = 8'h23;
    bus.b_in  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    done_at  = 0;
    got4     = '0;
    for (int i = 1; i <= W + 4; i++) begin
      @(negedge clk);
      bus.start = (i >= 2 && i <= 6);
      bus.in1   = 8'($urandom);
      bus.in2   = 8'($urandom);
      bus.b_in  = 1'($urandom);
      if (bus.done) begin
        done_cnt++;
        done_at = i;
        got4    = {bus.diff, bus.b_out, bus.ovf};
      end
    end
    bus.start = 1'b0;
    check_eq("ignore_start_done_count", done_cnt, 1);
    check_eq("ignore_start_done_time", done_at, W + 1);
    check_eq("ignore_start_result", {22'd0, got4}, {22'd0, 8'h37, 1'b0, 1'b0});

    // Asynchronous reset mid-operation.
    @(negedge clk);
    bus.in1   = 8'h10;
    bus.in2   = 8'h20;
    bus.b_in  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_outputs", {19'd0, bus.diff, bus.b_out, bus.ovf, bus.busy, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check_eq("async_rst_no_done", done_cnt, 0);
    do_op("post_rst", 8'h5A, 8'h23, 1'b0, res);
    check_eq("post_rst_result", {22'd0, res}, {22'd0, 8'h37, 1'b0, 1'b0});

    // Back-to-back: start held high, accepted every W+1 edges.
    bus.start = 1'b1;
    for (int e = 0; e < 1000 * (W + 1); e++) begin
      bus.in1  = 8'($urandom);
      bus.in2  = 8'($urandom);
      bus.b_in = 1'($urandom_range(1, 0));
      if (e % (W + 1) == 0) q.push_back(model(bus.in1, bus.in2, bus.b_in));
      @(posedge clk);
      @(negedge clk);
      if (e == 1000 * (W + 1) - 1) bus.start = 1'b0;
      check_eq("b2b_done_timing", bus.done, (e % (W + 1) == W));
      if (bus.done && q.size() > 0) begin
        exp = q.pop_front();
        check_eq("b2b_result", {22'd0, bus.diff, bus.b_out, bus.ovf}, {22'd0, exp});
      end
    end
    check_eq("b2b_all_results_seen", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor. Computes in1 - in2 - b_in over WIDTH cycles, one bit per clock, LSB first, using a single 1-bit full-subtractor cell and a registered borrow. It is the subtraction and sequential counterpart of the team's cascaded full-adder datapath, and feeds the ALU's SUB/CMP path and later the iterative divider. A start/busy/done handshake makes it usable by a multi-cycle controller.

Parameters:
WIDTH, 8, operand and result width in bits (legal: 2..32)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
in1  input  WIDTH  minuend; latched on accepted start
in2  input  WIDTH  subtrahend; latched on accepted start
b_in  input  1  borrow-in; latched on accepted start
diff  output  WIDTH  result in1 - in2 - b_in, modulo 2^WIDTH
b_out  output  1  borrow-out: 1 iff unsigned in1 < in2 + b_in
ovf  output  1  two's-complement overflow of the signed subtraction
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when results update

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE; diff=0, b_out=0, ovf=0, busy=0, done=0. Operand shift registers, borrow flop and bit counter are cleared. Any in-flight operation is abandoned with no done pulse.
- States: IDLE, RUN. busy = (state==RUN). done is a registered output.
- IDLE, start=1 at edge k:
  - latch in1/in2 into shift registers A/B and b_in into the borrow flop;
  - cnt=0; state=RUN.
- IDLE, start=0: hold all state.
- RUN, each edge: the cell takes a=A[0], b=B[0], br=borrow flop.
  - d = a^b^br
  - bo = (~a&b) | (~(a^b)&br)
  - shift d into the MSB of the result shift register; shift A and B right; borrow flop <= bo; cnt++.
- RUN, edge where cnt==WIDTH-1 (edge k+WIDTH):
  - diff <= final result register contents;
  - b_out <= bo;
  - ovf <= (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]), using latched operand MSBs;
  - done <= 1; state <= IDLE.
- Latency: done is high in the cycle after edge k+WIDTH, exactly WIDTH cycles after the accepting edge. busy is high for exactly WIDTH cycles.
- done clears on the next edge unless another completion occurs.
- diff, b_out and ovf hold their values until the next completion. They do not change during RUN.
- start while busy: ignored, no queuing. Input changes during RUN have no effect.
- start high in the cycle done is high: state is IDLE, so it is accepted. This allows back-to-back operations with a period of WIDTH+1 cycles.
- Widths: cnt is $clog2(WIDTH) bits. No arithmetic is wider than 1 bit. diff wraps modulo 2^WIDTH.

Decomposition:
- Shared package: state encoding constants (IDLE=1'b0, RUN=1'b1) and the default WIDTH constant, reused by the divider controller.
- One natural sub-module: full_subtractor. It is combinational: inputs a, b, bin; outputs d, bout. It is instantiated once and is the subtractive dual of the full-adder cell.
- Top level contains only the FSM, counter, shift registers and output registers.

Test Plan:
1. WIDTH=8, in1=0x5A, in2=0x23, b_in=0, start pulse -> busy high 8 cycles; done pulse 8 cycles after accept; diff=0x37, b_out=0, ovf=0.
2. in1=0x10, in2=0x20, b_in=0 -> diff=0xF0, b_out=1, ovf=0. Then in1=0x00, in2=0x00, b_in=1 -> diff=0xFF, b_out=1.
3. in1=0x80, in2=0x01 -> diff=0x7F, b_out=0, ovf=1. Then in1=0x7F, in2=0xFF -> diff=0x80, b_out=1, ovf=1.
4. start re-asserted with different operands at cycles 2..6 of RUN -> ignored; result still matches the first operands; exactly one done pulse.
5. Assert rst for one cycle at RUN cycle 4, asynchronously mid-cycle -> outputs go to 0 immediately; no done pulse. A fresh start then gives a correct result.
6. Hold start=1 continuously with new operands each accept -> accepts every 9 cycles; each done pulse carries the matching result; scoreboard against in1-in2-b_in for 1000 random vectors.
